// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle ADD/AND/NAND/NOR/SUB, iterative shift-add MUL and restoring DIV.
// Latency 1 for single-cycle ops, WIDTH+1 for MUL/DIV; start is ignored while busy, nothing queues.
module multicycle_alu #(
   parameter int WIDTH = 18,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_dz,
   output logic             flag_illegal
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_NOR  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_MUL  = 3'd5;
   localparam logic [2:0] OP_DIV  = 3'd6;
   localparam logic [2:0] OP_ILL  = 3'd7;

   state_t             state;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH:0]     add_sum;
   logic [WIDTH-1:0]   sc_res;
   logic [WIDTH-1:0]   sc_hi;
   logic               sc_carry;
   logic               sc_dz;
   logic               sc_ill;
   logic               iter_start;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic               div_ge;

   // Single-cycle results straight from the live inputs; only registered on accept.
   always_comb begin
      add_sum    = {1'b0, a} + {1'b0, b};
      sc_res     = '0;
      sc_hi      = '0;
      sc_carry   = 1'b0;
      sc_dz      = 1'b0;
      sc_ill     = 1'b0;
      case (op)
         OP_ADD: begin
            sc_res   = add_sum[WIDTH-1:0];
            sc_carry = add_sum[WIDTH];
         end
         OP_AND:  sc_res = a & b;
         OP_NAND: sc_res = ~(a & b);
         OP_NOR:  sc_res = ~(a | b);
         OP_SUB: begin
            sc_res   = a - b;
            sc_carry = (a < b);
         end
         OP_DIV: begin
            sc_res = '1;
            sc_hi  = a;
            sc_dz  = 1'b1;
         end
         default: sc_ill = (op == OP_ILL);
      endcase
      iter_start = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
   end

   // acc_lo holds the multiplier (MUL) or the dividend shifting into the quotient (DIV).
   always_comb begin
      mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, op_a}) : {1'b0, acc_hi};
      div_sh  = {acc_hi, acc_lo[WIDTH-1]};
      div_ge  = (div_sh >= {1'b0, op_b});
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         op_q         <= '0;
         op_a         <= '0;
         op_b         <= '0;
         acc_hi       <= '0;
         acc_lo       <= '0;
         cnt          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         result_hi    <= '0;
         flag_zero    <= 1'b0;
         flag_carry   <= 1'b0;
         flag_dz      <= 1'b0;
         flag_illegal <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q <= op;
                  op_a <= a;
                  op_b <= b;
                  if (iter_start) begin
                     busy   <= 1'b1;
                     cnt    <= CNT_W'(WIDTH);
                     acc_hi <= '0;
                     acc_lo <= (op == OP_MUL) ? b : a;
                     state  <= (op == OP_MUL) ? S_MUL : S_DIV;
                  end else begin
                     result       <= sc_res;
                     result_hi    <= sc_hi;
                     flag_zero    <= (sc_res == '0);
                     flag_carry   <= sc_carry;
                     flag_dz      <= sc_dz;
                     flag_illegal <= sc_ill;
                     done         <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= S_DONE;
            end
            S_DIV: begin
               acc_hi <= div_ge ? WIDTH'(div_sh - {1'b0, op_b}) : div_sh[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
               cnt    <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= S_DONE;
            end
            S_DONE: begin
               result       <= acc_lo;
               result_hi    <= acc_hi;
               flag_zero    <= (acc_lo == '0);
               flag_carry   <= (op_q == OP_MUL) && (acc_hi != '0);
               flag_dz      <= 1'b0;
               flag_illegal <= 1'b0;
               busy         <= 1'b0;
               done         <= 1'b1;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed scenarios plus random ops against an arithmetic reference model.
module tb_multicycle_alu;

   localparam int W = 18;
   localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z;
      logic         c;
      logic         dz;
      logic         ill;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset_n = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, flag_zero, flag_carry, flag_dz, flag_illegal;
   logic [W-1:0] result, result_hi;

   int checks = 0;
   int errors = 0;

   multicycle_alu #(.WIDTH(W)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .result_hi(result_hi),
      .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_dz(flag_dz),
      .flag_illegal(flag_illegal)
   );

   always #5 clock = ~clock;

   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint unsigned ux, uy, r, h;
      exp_t e;
      ux = x; uy = y; r = 0; h = 0; e = '0;
      case (o)
         3'd0: begin r = ux + uy; e.c = (r > MASK); end
         3'd1: r = ux & uy;
         3'd2: r = ~(ux & uy);
         3'd3: r = ~(ux | uy);
         3'd4: begin r = ux - uy; e.c = (ux < uy); end
         3'd5: begin r = ux * uy; h = r >> W; e.c = (h != 0); end
         3'd6: begin
            if (uy == 0) begin r = MASK; h = ux; e.dz = 1'b1; end
            else begin r = ux / uy; h = ux % uy; end
         end
         default: e.ill = 1'b1;
      endcase
      r = r & MASK;
      e.res = r[W-1:0];
      e.hi  = h[W-1:0];
      e.z   = (r == 0);
      return e;
   endfunction

   // Edges after the accept edge at which done is first visible.
   function automatic int model_lat(input logic [2:0] o, input logic [W-1:0] y);
      return ((o == 3'd5) || (o == 3'd6 && y != '0)) ? W + 1 : 0;
   endfunction

   function automatic exp_t observed();
      return {result, result_hi, flag_zero, flag_carry, flag_dz, flag_illegal};
   endfunction

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clock); #1;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         @(posedge clock); #1;
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, flag_zero, flag_carry, flag_dz, flag_illegal} !== 6'b0 || result !== '0 || result_hi !== '0) begin
         errors++;
         $display("FAIL reset_async got busy=%b done=%b res=%h hi=%h flags=%b%b%b%b want all zero",
                  busy, done, result, result_hi, flag_zero, flag_carry, flag_dz, flag_illegal);
      end
      @(posedge clock); #1 reset_n = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b done=%b res=%h want 0 0 0", busy, done, result);
      end
   endtask

   task automatic test_add_sub_nor();
      exp_t e;
      issue(3'd0, 18'h3FFFF, 18'h00001);
      e = model(3'd0, 18'h3FFFF, 18'h00001);
      checks++;
      if (done !== 1'b1 || observed() !== e || result !== 18'h0 || flag_carry !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap got done=%b bundle=%h want done=1 bundle=%h", done, observed(), e);
      end
      issue(3'd4, 18'h00005, 18'h00007);
      e = model(3'd4, 18'h00005, 18'h00007);
      checks++;
      if (done !== 1'b1 || observed() !== e || result !== 18'h3FFFE) begin
         errors++;
         $display("FAIL sub_borrow got done=%b bundle=%h want done=1 bundle=%h", done, observed(), e);
      end
      issue(3'd3, 18'h0, 18'h0);
      start = 1'b0;
      e = model(3'd3, 18'h0, 18'h0);
      checks++;
      if (done !== 1'b1 || observed() !== e || result !== 18'h3FFFF) begin
         errors++;
         $display("FAIL nor_b2b got done=%b bundle=%h want done=1 bundle=%h", done, observed(), e);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || result !== 18'h3FFFF) begin
         errors++;
         $display("FAIL done_drop got done=%b res=%h want 0 3ffff", done, result);
      end
   endtask

   task automatic test_mul_ignore();
      exp_t e;
      int cyc, busy_cnt;
      e = model(3'd5, 18'h00123, 18'h00456);
      issue(3'd5, 18'h00123, 18'h00456);
      start = 1'b0;
      cyc = 0; busy_cnt = 0;
      while (!done && cyc < W + 6) begin
         if (busy) busy_cnt++;
         start = (cyc == 4);
         if (start) begin op = 3'd0; a = 18'h1; b = 18'h1; end
         @(posedge clock); #1;
         cyc++;
      end
      start = 1'b0;
      checks++;
      if (!done || cyc !== W + 1 || busy_cnt !== W + 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mul_timing got done=%b edge=%0d busy_cycles=%0d busy_end=%b want 1 %0d %0d 0",
                  done, cyc, busy_cnt, busy, W + 1, W + 1);
      end
      checks++;
      if (observed() !== e || result !== 18'h0EDC2 || result_hi !== 18'h00001 || flag_carry !== 1'b1) begin
         errors++;
         $display("FAIL mul_result got %h want %h", observed(), e);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || observed() !== e) begin
         errors++;
         $display("FAIL mul_hold got done=%b busy=%b bundle=%h want 0 0 %h", done, busy, observed(), e);
      end
   endtask

   task automatic test_div();
      exp_t e;
      int cyc;
      e = model(3'd6, 18'd100, 18'd7);
      issue(3'd6, 18'd100, 18'd7);
      start = 1'b0;
      wait_done(W + 6, cyc);
      checks++;
      if (cyc !== W + 1 || observed() !== e || result !== 18'h0000E || result_hi !== 18'h00002) begin
         errors++;
         $display("FAIL div_basic got edge=%0d bundle=%h want %0d %h", cyc, observed(), W + 1, e);
      end
      e = model(3'd6, 18'h00055, 18'h0);
      issue(3'd6, 18'h00055, 18'h0);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || observed() !== e || result !== 18'h3FFFF || flag_dz !== 1'b1) begin
         errors++;
         $display("FAIL div_zero got done=%b busy=%b bundle=%h want 1 0 %h", done, busy, observed(), e);
      end
      e = model(3'd6, 18'd9, 18'd200);
      issue(3'd6, 18'd9, 18'd200);
      start = 1'b0;
      wait_done(W + 6, cyc);
      checks++;
      if (cyc !== W + 1 || observed() !== e || result !== 18'd0 || result_hi !== 18'd9) begin
         errors++;
         $display("FAIL div_small got edge=%0d bundle=%h want %0d %h", cyc, observed(), W + 1, e);
      end
   endtask

   task automatic test_reset_abort();
      int seen;
      issue(3'd6, 18'd1000, 18'd3);
      start = 1'b0;
      repeat (5) begin @(posedge clock); #1; end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || result_hi !== '0) begin
         errors++;
         $display("FAIL abort_clear got busy=%b done=%b res=%h hi=%h want 0 0 0 0", busy, done, result, result_hi);
      end
      #1 reset_n = 1'b1;
      seen = 0;
      repeat (W + 4) begin
         @(posedge clock); #1;
         if (done) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_no_done got done_pulses=%0d want 0", seen);
      end
      issue(3'd0, 18'd2, 18'd3);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || result !== 18'd5 || flag_carry !== 1'b0) begin
         errors++;
         $display("FAIL abort_recover got done=%b res=%h want 1 00005", done, result);
      end
   endtask

   task automatic test_illegal();
      issue(3'd7, 18'h12345, 18'h0);
      checks++;
      if (done !== 1'b1 || flag_illegal !== 1'b1 || result !== '0 || result_hi !== '0 || flag_zero !== 1'b1) begin
         errors++;
         $display("FAIL illegal_op got done=%b ill=%b res=%h z=%b want 1 1 0 1", done, flag_illegal, result, flag_zero);
      end
      issue(3'd1, 18'h0F0F0, 18'h0FF00);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || flag_illegal !== 1'b0 || result !== 18'h0F000) begin
         errors++;
         $display("FAIL and_after_ill got ill=%b res=%h want 0 0f000", flag_illegal, result);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  o;
      logic [31:0] r1, r2;
      exp_t        e;
      for (int i = 0; i < 16; i++) begin
         r1 = $urandom; r2 = $urandom;
         o = 3'($urandom_range(0, 5));
         if (o == 3'd5) o = 3'd7;
         if (o == 3'd5 || o == 3'd6) r2 = 32'd0;
         e = model(o, r1[W-1:0], r2[W-1:0]);
         issue(o, r1[W-1:0], r2[W-1:0]);
         checks++;
         if (done !== 1'b1 || busy !== 1'b0 || observed() !== e) begin
            errors++;
            $display("FAIL b2b_%0d op=%0d got done=%b bundle=%h want 1 %h", i, o, done, observed(), e);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] r1, r2;
      logic [W-1:0] x, y;
      exp_t        e;
      int          cyc, sel;
      for (int i = 0; i < 60; i++) begin
         r1 = $urandom; r2 = $urandom;
         o = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         x = r1[W-1:0];
         y = r2[W-1:0];
         if (sel == 0) y = '0;
         else if (sel == 1) x = '0;
         else if (sel == 2) y = {W{1'b1}};
         else if (sel == 3) y = {12'b0, r2[5:0]};
         e = model(o, x, y);
         issue(o, x, y);
         start = 1'b0;
         a = ~x; b = ~y; op = 3'd7;
         wait_done(W + 6, cyc);
         checks++;
         if (cyc !== model_lat(o, y) || observed() !== e) begin
            errors++;
            $display("FAIL rand_%0d op=%0d a=%h b=%h got edge=%0d bundle=%h want %0d %h",
                     i, o, x, y, cyc, observed(), model_lat(o, y), e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub_nor();
      test_mul_ignore();
      test_div();
      test_reset_abort();
      test_illegal();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
